uart_frame_seq: RTL
===================

# uart_frame_seq

Parametrised bit-slot sequencer for the serial transmit path. It walks a multi-character frame slot by slot: start bit, data bits, optional parity and stop bits. Every slot advances on one bit-rate enable tick. Flow control through `rts` is applied only at character boundaries. The block's outputs drive the shift register / mux stage and the frame-complete logic; it is the generalised successor of the fixed 40-slot frame counter.

## Interface
- `DATA_BITS`, default 8: data bits per character; legal range 5..9.
- `CHARS`, default 5: characters per frame; legal range 1..16.
- `STOP_BITS`, default 1: stop slots per character; legal values 1 or 2.
- `clk` input, 1 bit: the single clock. All logic is on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-low. It is sampled on the `clk` rising edge and is active when 0.
- `tick` input, 1: bit-rate enable, one `clk` wide. The sequencer advances only on cycles where `tick` is 1.
- `start` input, 1: frame request. A level or a pulse is accepted.
- `par_en` input, 1: inserts a parity slot after the data bits. It is latched at frame start.
- `rts` input, 1: clear-to-send. It gates the start of each character.
- `busy` output, 1: 1 whenever the state is not IDLE.
- `phase` output, 2: current slot type. 0 = START, 1 = DATA, 2 = PARITY, 3 = STOP. It reads 0 in IDLE and HOLD; use `busy` to qualify it.
- `bit_idx` output, 4: data bit index 0..DATA_BITS-1 during DATA, and stop index during STOP. It is 0 in every other state.
- `char_idx` output, 4: index of the current character, 0..CHARS-1.
- `cout` output, 8: linear slot number since frame start. It is 0 at the first START slot.
- `last_bit` output, 1: 1 while the current slot is the final stop slot of the final character.
- `frame_done` output, 1: single-cycle pulse when the frame completes.

## Operation
- The states are IDLE, START, DATA, PARITY, STOP and HOLD. Every transition except IDLE→START requires `tick`=1; IDLE→START additionally requires `rts`=1.
- `req` is an internal pending flag.
  - It is set by `start`=1 while in IDLE.
  - It is cleared on IDLE→START.
  - `start` while `busy` is ignored and does not queue a request.
- IDLE→START requires `req` (or `start`) =1, `tick`=1 and `rts`=1.
  - On this transition `par_en` is latched into `par_q`, and `char_idx`, `cout` and `bit_idx` are set to 0.
- START→DATA: `bit_idx` becomes 0.
- DATA: `bit_idx` increments on each tick.
  - At `bit_idx`=DATA_BITS-1 the next state is PARITY if `par_q`=1, else STOP.
- PARITY→STOP: `bit_idx` becomes 0.
- STOP: `bit_idx` increments on each tick.
  - At `bit_idx`=STOP_BITS-1, the end of the character is reached.
- At end of character:
  - If `char_idx`=CHARS-1, the next state is IDLE and `frame_done`=1 for the next cycle.
  - Else `char_idx` increments, and the next state is START if `rts`=1 or HOLD if `rts`=0.
- HOLD→START on a tick with `rts`=1. `cout` does not advance in HOLD.
- `rts`=0 inside a character (START through STOP) has no effect; the character always completes.
- `cout` increments by 1 on every tick that advances a slot, except the final one, where it returns to 0 in IDLE.
  - Frame length per character is L = 1 + DATA_BITS + `par_q` + STOP_BITS.
  - Frame length is CHARS·L slots. The maximum is 16·13 = 208 slots, which fits 8 bits.
- Reset mid-operation: the state goes to IDLE on the next edge, all outputs reset and `req` is cleared. There is no partial-frame recovery.

## Timing
- Reset values: all outputs 0 (`busy`, `phase`, `bit_idx`, `char_idx`, `cout`, `last_bit`, `frame_done`), plus `req`=0 and `par_q`=0.
- All outputs are registered. They reflect the new slot in the `clk` cycle after the advancing tick edge.
- Start latency:
  - With `start` high and `tick`/`rts` already high in the same cycle, `busy`=1 one `clk` later.
  - Otherwise `busy` rises one `clk` after the first qualifying tick.
- `last_bit` is 1 for exactly the duration of the final slot, from its entry edge to the next tick.
- `frame_done` is high for exactly one `clk`, in the first IDLE cycle, coincident with `busy` falling.
- A new frame may start on the very next qualifying tick after `frame_done` if `start` is held high. There is no mandatory gap.
- Every state including IDLE samples `rst` first; `rst`=0 overrides `tick` and `start`.

## Test plan
1. Default parameters, `par_en`=0, `rts`=1, tick every 4 clk, `start` pulse.
   - Required: 50 slots; `cout` runs 0..49; `char_idx` runs 0..4.
   - Required: `last_bit` high during slot 49; one `frame_done` pulse; then IDLE with `cout`=0.
2. As scenario 1 but `par_en`=1, deasserted again after frame start.
   - Required: 55 slots, with PARITY at `cout`=9, 20, 31, 42, 53.
   - Required: latched `par_q` holds for the whole frame.
3. Drop `rts` to 0 during char 1 data bits, raise it 12 ticks after char 1's stop slot.
   - Required: char 1 completes; HOLD for those ticks with `cout`=20 frozen.
   - Required: START of char 2 on the first tick with `rts`=1.
4. Drive `rst`=0 at `cout`=23.
   - Required: next edge gives all outputs 0, state IDLE.
   - Required: with `start` low, `busy` stays 0 after `rst` returns to 1.
5. Parameters DATA_BITS=7, STOP_BITS=2, CHARS=2, `par_en`=1.
   - Required: L=11, 22 slots.
   - Required: STOP `bit_idx` 0 then 1; `frame_done` after slot 21.
6. Assert `start` while `busy`, and hold `start` high across `frame_done`.
   - Required: the mid-frame request is ignored.
   - Required: the held `start` launches the next frame on the first qualifying tick after `frame_done`.

Source files
------------

// File: rtl/uart_frame_seq.sv
// uart_frame_seq: bit-slot sequencer for a multi-character UART transmit frame, rts-gated at character boundaries.
module uart_frame_seq #(
   parameter int DATA_BITS = 8,
   parameter int CHARS     = 5,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic       par_en,
   input  logic       rts,
   output logic       busy,
   output logic [1:0] phase,
   output logic [3:0] bit_idx,
   output logic [3:0] char_idx,
   output logic [7:0] cout,
   output logic       last_bit,
   output logic       frame_done
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, HOLD} state_t;
   state_t state, state_n;
   logic req, req_n, par_q, par_n, done_n, last_n;
   logic [3:0] bit_n, char_n;
   logic [7:0] cout_n;
   logic [1:0] phase_n;
   logic last_char, last_stop, last_data;
   assign last_char = char_idx == 4'(CHARS - 1);
   assign last_stop = bit_idx == 4'(STOP_BITS - 1);
   assign last_data = bit_idx == 4'(DATA_BITS - 1);
   always_comb begin
      state_n = state;
      req_n = req;
      par_n = par_q;
      bit_n = bit_idx;
      char_n = char_idx;
      cout_n = cout;
      done_n = 1'b0;
      case (state)
         IDLE: begin
            req_n = req | start;
            if ((req | start) && tick && rts) begin
               state_n = START;
               req_n = 1'b0;
               par_n = par_en;
               bit_n = '0;
               char_n = '0;
               cout_n = '0;
            end
         end
         START: if (tick) begin
            state_n = DATA;
            bit_n = '0;
            cout_n = cout + 8'd1;
         end
         DATA: if (tick) begin
            state_n = last_data ? (par_q ? PARITY : STOP) : DATA;
            bit_n = last_data ? 4'd0 : bit_idx + 4'd1;
            cout_n = cout + 8'd1;
         end
         PARITY: if (tick) begin
            state_n = STOP;
            bit_n = '0;
            cout_n = cout + 8'd1;
         end
         STOP: if (tick) begin
            bit_n = last_stop ? 4'd0 : bit_idx + 4'd1;
            cout_n = cout + 8'd1;
            if (last_stop && last_char) begin
               state_n = IDLE;
               char_n = '0;
               cout_n = '0;
               done_n = 1'b1;
            end else if (last_stop) begin
               state_n = rts ? START : HOLD;
               char_n = char_idx + 4'd1;
            end
         end
         HOLD: if (tick && rts) state_n = START;
         default: state_n = IDLE;
      endcase
      phase_n = state_n == DATA ? 2'd1 : state_n == PARITY ? 2'd2 : state_n == STOP ? 2'd3 : 2'd0;
      last_n = state_n == STOP && bit_n == 4'(STOP_BITS - 1) && char_n == 4'(CHARS - 1);
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         req <= 1'b0;
         par_q <= 1'b0;
         bit_idx <= '0;
         char_idx <= '0;
         cout <= '0;
         busy <= 1'b0;
         phase <= '0;
         last_bit <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state <= state_n;
         req <= req_n;
         par_q <= par_n;
         bit_idx <= bit_n;
         char_idx <= char_n;
         cout <= cout_n;
         busy <= state_n != IDLE;
         phase <= phase_n;
         last_bit <= last_n;
         frame_done <= done_n;
      end
   end
endmodule
